xilinx_board_io_ctrl: RTL and testbench

Parametrised board-I/O front end for the FPGA PULPissimo targets. It replaces fixed one-to-one pad aliasing of buttons, switches and LEDs with conditioned logic.
- Each of NUM_IN raw button/switch inputs is synchronised and debounced, and produces edge pulses and maskable sticky interrupts.
- Each of NUM_LED outputs is driven in off / on / PWM / blink mode.
- Sits in the board top, between the board pins and the SoC GPIO/event inputs.

---
 rtl/xilinx_board_io_pkg.sv | 26 ++
 rtl/xilinx_board_io_debounce.sv | 76 +++++++
 rtl/xilinx_board_io_ctrl.sv | 170 +++++++++++++++++
 tb/tb_xilinx_board_io_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_board_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xilinx_board_io_pkg
// Description : Shared types and helpers for the board I/O front end
//               (LED mode encoding, debounce counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package xilinx_board_io_pkg;

    // LED drive mode, two bits per LED on led_mode_i
    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_PWM   = 2'b10,
        LED_BLINK = 2'b11
    } led_mode_e;

    // Width of a counter that must hold values 0..cycles
    function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xilinx_board_io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : xilinx_board_io_debounce
// Description : One input channel: two-flop synchroniser, stable-level
//               debounce filter and registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module xilinx_board_io_debounce
    import xilinx_board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pad,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned             c_cnt_w    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0]      c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;

    // Two-flop synchroniser for the asynchronous pad
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_pad;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + c_cnt_w'(1);
        end
    end

    // Output level register; pulses mark the first cycle the new level is shown
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= r_stable;
            r_rise  <= r_stable & ~r_level;
            r_fall  <= ~r_stable & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/xilinx_board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xilinx_board_io_ctrl
// Description : Board I/O front end: debounced inputs with edge pulses and
//               sticky rise interrupts, LEDs in off/on/PWM/blink mode.
// Revision    : 1.0 - initial release
// ============================================================================
module xilinx_board_io_ctrl
    import xilinx_board_io_pkg::*;
#(
    parameter int unsigned NUM_IN          = 7,
    parameter int unsigned NUM_LED         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PWM_WIDTH       = 8,
    parameter int unsigned BLINK_WIDTH     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_IN-1:0]            pad_in_i,
    output logic [NUM_IN-1:0]            in_level_o,
    output logic [NUM_IN-1:0]            in_rise_o,
    output logic [NUM_IN-1:0]            in_fall_o,
    input  logic [NUM_IN-1:0]            irq_en_i,
    input  logic [NUM_IN-1:0]            irq_clr_i,
    output logic [NUM_IN-1:0]            irq_pending_o,
    output logic                         irq_o,
    input  logic [2*NUM_LED-1:0]         led_mode_i,
    input  logic [PWM_WIDTH*NUM_LED-1:0] led_duty_i,
    input  logic [BLINK_WIDTH-1:0]       blink_half_i,
    output logic [NUM_LED-1:0]           led_o
);

    logic [NUM_IN-1:0]                   w_level;
    logic [NUM_IN-1:0]                   w_rise;
    logic [NUM_IN-1:0]                   w_fall;
    logic [NUM_IN-1:0]                   r_pending;

    logic [PWM_WIDTH-1:0]                r_frame;
    logic                                w_frame_wrap;
    logic [NUM_LED-1:0][PWM_WIDTH-1:0]   w_duty_in;
    logic [NUM_LED-1:0][PWM_WIDTH-1:0]   r_duty;

    logic [BLINK_WIDTH-1:0]              r_blink_cnt;
    logic [BLINK_WIDTH-1:0]              w_blink_last;
    logic                                r_phase;

    logic [NUM_LED-1:0]                  w_led_next;
    logic [NUM_LED-1:0]                  r_led;

    // ------------------------------------------------------------------
    // Input channels
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
            xilinx_board_io_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .i_clk   (clk_i),
                .i_rst_n (rst_ni),
                .i_pad   (pad_in_i[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi]),
                .o_fall  (w_fall[gi])
            );
        end
    endgenerate

    assign in_level_o = w_level;
    assign in_rise_o  = w_rise;
    assign in_fall_o  = w_fall;

    // Sticky pending flags; a new rise wins over a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~irq_clr_i) | (w_rise & irq_en_i);
        end
    end

    assign irq_pending_o = r_pending;
    assign irq_o         = |r_pending;

    // ------------------------------------------------------------------
    // PWM frame and duty shadows
    // ------------------------------------------------------------------
    assign w_frame_wrap = (r_frame == '1);
    assign w_duty_in    = led_duty_i;

    // Free-running frame counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame <= '0;
        end else begin
            r_frame <= r_frame + PWM_WIDTH'(1);
        end
    end

    // Duty shadows capture at frame start so a frame never mixes two duties
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_duty <= '0;
        end else if (r_frame == '0) begin
            r_duty <= w_duty_in;
        end
    end

    // ------------------------------------------------------------------
    // Blink phase, counted in whole PWM frames
    // ------------------------------------------------------------------
    assign w_blink_last = (blink_half_i == '0) ? '0 : (blink_half_i - BLINK_WIDTH'(1));

    // Toggle the shared phase every max(blink_half_i,1) frames
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_frame_wrap) begin
            if (r_blink_cnt == w_blink_last) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // LED mode selection
    // ------------------------------------------------------------------
    generate
        for (genvar gl = 0; gl < NUM_LED; gl++) begin : g_led
            led_mode_e            w_mode;
            logic [PWM_WIDTH-1:0] w_duty_cur;
            logic                 w_pwm_on;
            logic                 w_led_bit;

            assign w_mode     = led_mode_e'(led_mode_i[2*gl +: 2]);
            // At frame start the shadow is still loading, so use the incoming duty
            assign w_duty_cur = (r_frame == '0) ? w_duty_in[gl] : r_duty[gl];
            assign w_pwm_on   = (r_frame < w_duty_cur);

            // Select the LED source for this channel's mode
            always_comb begin
                w_led_bit = 1'b0;
                case (w_mode)
                    LED_OFF:   w_led_bit = 1'b0;
                    LED_ON:    w_led_bit = 1'b1;
                    LED_PWM:   w_led_bit = w_pwm_on;
                    LED_BLINK: w_led_bit = r_phase;
                endcase
            end

            assign w_led_next[gl] = w_led_bit;
        end
    endgenerate

    // Registered LED drive
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign led_o = r_led;

endmodule
`default_nettype wire

// File: tb/tb_xilinx_board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_xilinx_board_io_ctrl
// Description : Randomised self-checking bench for xilinx_board_io_ctrl
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xilinx_board_io_ctrl;

    localparam int NI    = 3;
    localparam int NL    = 4;
    localparam int DB    = 4;
    localparam int PW    = 4;
    localparam int BW    = 4;
    localparam int FRAME = 1 << PW;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic [NI-1:0]     pad_in_i;
    logic [NI-1:0]     in_level_o;
    logic [NI-1:0]     in_rise_o;
    logic [NI-1:0]     in_fall_o;
    logic [NI-1:0]     irq_en_i;
    logic [NI-1:0]     irq_clr_i;
    logic [NI-1:0]     irq_pending_o;
    logic              irq_o;
    logic [2*NL-1:0]   led_mode_i;
    logic [PW*NL-1:0]  led_duty_i;
    logic [BW-1:0]     blink_half_i;
    logic [NL-1:0]     led_o;

    always #5 clk_i = ~clk_i;

    xilinx_board_io_ctrl #(
        .NUM_IN          (NI),
        .NUM_LED         (NL),
        .DEBOUNCE_CYCLES (DB),
        .PWM_WIDTH       (PW),
        .BLINK_WIDTH     (BW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pad_in_i      (pad_in_i),
        .in_level_o    (in_level_o),
        .in_rise_o     (in_rise_o),
        .in_fall_o     (in_fall_o),
        .irq_en_i      (irq_en_i),
        .irq_clr_i     (irq_clr_i),
        .irq_pending_o (irq_pending_o),
        .irq_o         (irq_o),
        .led_mode_i    (led_mode_i),
        .led_duty_i    (led_duty_i),
        .blink_half_i  (blink_half_i),
        .led_o         (led_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DB:0]   m_hist [NI];   // pad samples, bit 0 = most recent edge
    logic [NI-1:0] m_accept;      // level accepted by the filter
    logic [NI-1:0] m_level;
    logic [NI-1:0] m_rise;
    logic [NI-1:0] m_fall;
    logic [NI-1:0] m_pend;
    logic [NL-1:0] m_led;
    int            m_fduty [NL];
    int            m_half;
    int            n_edge;
    int            hold [NI];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) m_hist[i] = '0;
        for (int j = 0; j < NL; j++) m_fduty[j] = 0;
        m_accept = '0; m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_led = '0;
        n_edge = 0;
    endtask

    // Advance the model by one rising clock edge using the inputs now applied
    task automatic model_step();
        int f, ph, mode, duty;
        f  = n_edge % FRAME;
        ph = ((n_edge / FRAME) / m_half) % 2;
        m_pend = (m_pend & ~irq_clr_i) | (m_rise & irq_en_i);
        for (int i = 0; i < NI; i++) begin
            m_rise[i]  = m_accept[i] & ~m_level[i];
            m_fall[i]  = ~m_accept[i] & m_level[i];
            m_level[i] = m_accept[i];
            // synchronised samples seen over the last DB edges all oppose the level
            if (m_hist[i][DB:1] == {DB{~m_accept[i]}}) m_accept[i] = ~m_accept[i];
            m_hist[i] = {m_hist[i][DB-1:0], pad_in_i[i]};
        end
        for (int j = 0; j < NL; j++) begin
            duty = int'(led_duty_i[PW*j +: PW]);
            mode = int'(led_mode_i[2*j +: 2]);
            if (f == 0) m_fduty[j] = duty;
            case (mode)
                0:       m_led[j] = 1'b0;
                1:       m_led[j] = 1'b1;
                2:       m_led[j] = (f < m_fduty[j]);
                default: m_led[j] = ph[0];
            endcase
        end
        n_edge++;
    endtask

    task automatic check_outputs();
        check_val("level",   32'(in_level_o),    32'(m_level));
        check_val("rise",    32'(in_rise_o),     32'(m_rise));
        check_val("fall",    32'(in_fall_o),     32'(m_fall));
        check_val("rf_excl", 32'(in_rise_o & in_fall_o), 32'(0));
        check_val("pending", 32'(irq_pending_o), 32'(m_pend));
        check_val("irq",     32'(irq_o),         32'(|m_pend));
        check_val("led",     32'(led_o),         32'(m_led));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_level"},   32'(in_level_o),    32'(0));
        check_val({tag, "_rise"},    32'(in_rise_o),     32'(0));
        check_val({tag, "_fall"},    32'(in_fall_o),     32'(0));
        check_val({tag, "_pending"}, 32'(irq_pending_o), 32'(0));
        check_val({tag, "_irq"},     32'(irq_o),         32'(0));
        check_val({tag, "_led"},     32'(led_o),         32'(0));
    endtask

    // Assert reset between edges, hold it with pads high, release on a falling edge
    task automatic do_reset();
        @(negedge clk_i);
        #2;
        pad_in_i = '1;
        rst_ni   = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (3) begin
            @(posedge clk_i);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk_i);
        blink_half_i = BW'($urandom_range(0, 3));
        m_half = (blink_half_i == '0) ? 1 : int'(blink_half_i);
        for (int i = 0; i < NI; i++) hold[i] = 8;
        model_reset();
        rst_ni = 1'b1;
    endtask

    task automatic drive_random(input int cyc);
        for (int i = 0; i < NI; i++) begin
            if (hold[i] == 0) begin
                pad_in_i[i] = 1'($urandom_range(0, 1));
                hold[i]     = $urandom_range(1, 9);
            end else begin
                hold[i]--;
            end
            irq_clr_i[i] = ($urandom_range(0, 7) == 0);
        end
        if (cyc % 100 == 0) irq_en_i = NI'($urandom_range(0, (1 << NI) - 1));
        if (cyc % 40 == 0)  led_mode_i = (2*NL)'($urandom);
        for (int j = 0; j < NL; j++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       led_duty_i[PW*j +: PW] = '0;
                    1:       led_duty_i[PW*j +: PW] = '1;
                    default: led_duty_i[PW*j +: PW] = PW'($urandom);
                endcase
            end
        end
    endtask

    initial begin
        pad_in_i     = '0;
        irq_en_i     = '0;
        irq_clr_i    = '0;
        led_mode_i   = '0;
        led_duty_i   = '0;
        blink_half_i = '0;
        m_half       = 1;
        model_reset();
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int cyc = 0; cyc < 600; cyc++) begin
                drive_random(cyc);
                @(posedge clk_i);
                model_step();
                #1;
                check_outputs();
                @(negedge clk_i);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
